ibuf: RTL and testbench



---
 rtl/ibuf_pkg.sv | 12 +
 rtl/ibuf_sync.sv | 26 ++
 rtl/ibuf.sv | 85 ++++++++
 tb/tb_ibuf.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ibuf_pkg.sv
// Shared constants for the ibuf pad input buffer: parameter defaults and
// counter widths used by the conditioning logic.
package ibuf_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_LEN_DEF  = 3;
  localparam int ACT_TIMEOUT_DEF = 24;

  localparam int FC_W = 4;
  localparam int AC_W = 16;

endpackage

// File: rtl/ibuf_sync.sv
// N-flop synchronizer bringing an asynchronous pad level into the osc domain.
// The output is the last flop of a plain shift chain.
module ibuf_sync
  import ibuf_pkg::*;
#(
  parameter int N = SYNC_STAGES_DEF
) (
  input  logic osc,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] s;

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= {s[N-2:0], d};
    end
  end

  assign q = s[N-1];

endmodule

// File: rtl/ibuf.sv
// Pad input buffer: combinational pass-through plus an osc-domain conditioned
// copy (synchronized, glitch-filtered, edge pulses, activity monitor).
module ibuf
  import ibuf_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF,
  parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEF
) (
  input  logic osc,
  input  logic rst,
  input  logic I,
  output logic O,
  output logic o_sync,
  output logic o_filt,
  output logic rise,
  output logic fall,
  output logic active
);

  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
  localparam logic [AC_W-1:0] AC_LOAD = AC_W'(ACT_TIMEOUT - 1);

  logic [FC_W-1:0] fc;
  logic [AC_W-1:0] ac;
  logic            pf;
  logic            edge_seen;

  // Raw pad path stays purely combinational so core logic sees it undelayed.
  assign O = I;

  ibuf_sync #(
    .N (SYNC_STAGES)
  ) u_sync (
    .osc (osc),
    .rst (rst),
    .d   (I),
    .q   (o_sync)
  );

  // The counter only runs while the synchronized level disagrees with the
  // filtered one, so any short pulse leaves fc back at zero.
  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      fc     <= '0;
      o_filt <= 1'b0;
    end else if (o_sync == o_filt) begin
      fc <= '0;
    end else if (fc == FC_LAST) begin
      o_filt <= o_sync;
      fc     <= '0;
    end else begin
      fc <= fc + FC_W'(1);
    end
  end

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      pf <= 1'b0;
    end else begin
      pf <= o_filt;
    end
  end

  assign rise      = o_filt & ~pf;
  assign fall      = ~o_filt & pf;
  assign edge_seen = rise | fall;

  // A new edge wins over the countdown, so an edge landing on ac == 0 keeps
  // active asserted without a gap.
  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      ac     <= '0;
      active <= 1'b0;
    end else if (edge_seen) begin
      ac     <= AC_LOAD;
      active <= 1'b1;
    end else if (ac != '0) begin
      ac <= ac - AC_W'(1);
    end else begin
      active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ibuf.sv
// Self-checking bench for ibuf: a default instance with an edge scoreboard
// and a second instance with a short synchronizer/filter configuration.
module tb_ibuf;

  logic osc = 1'b0;
  logic rst = 1'b1;
  logic I   = 1'b0;
  logic I2  = 1'b0;

  logic O, o_sync, o_filt, rise, fall, active;
  logic O2, o_sync2, o_filt2, rise2, fall2, active2;

  int cyc     = 0;
  int n_chk   = 0;
  int n_fail  = 0;

  typedef struct {
    logic is_rise;
    int   cyc;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;

  ibuf dut (
    .osc    (osc),
    .rst    (rst),
    .I      (I),
    .O      (O),
    .o_sync (o_sync),
    .o_filt (o_filt),
    .rise   (rise),
    .fall   (fall),
    .active (active)
  );

  ibuf #(
    .SYNC_STAGES (3),
    .FILTER_LEN  (1),
    .ACT_TIMEOUT (2)
  ) dut2 (
    .osc    (osc),
    .rst    (rst),
    .I      (I2),
    .O      (O2),
    .o_sync (o_sync2),
    .o_filt (o_filt2),
    .rise   (rise2),
    .fall   (fall2),
    .active (active2)
  );

  always #5 osc = ~osc;

  always @(posedge osc) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic r, input int c);
    ev_t e;
    e.is_rise = r;
    e.cyc     = c;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge osc);
    #1;
  endtask

  // Edge pulses of the default instance are matched in order against the
  // events queued when the stimulus was applied.
  always @(negedge osc) begin
    if (rise || fall) begin
      chk("edge_excl", rise & fall, 0);
      chk("sb_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_ev = sb.pop_front();
        chk("edge_kind", rise, mon_ev.is_rise);
        chk("edge_cyc", cyc, mon_ev.cyc);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    int c;

    // Reset held: O tracks I, everything else stays cleared.
    pat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      I = pat[i];
      step();
      chk("rst_O", O, pat[i]);
      chk("rst_sync", o_sync, 0);
      chk("rst_filt", o_filt, 0);
      chk("rst_rise", rise, 0);
      chk("rst_fall", fall, 0);
      chk("rst_act", active, 0);
    end
    I = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();

    // Clean step followed by the activity timeout.
    c = cyc;
    I = 1'b1;
    push(1'b1, c + 5);
    for (int k = 1; k <= 31; k++) begin
      step();
      chk("O_pass", O, I);
      chk("step_sync", o_sync, k >= 2);
      chk("step_filt", o_filt, k >= 5);
      chk("step_rise", rise, k == 5);
      chk("act_timeout", active, (k >= 6) && (k <= 29));
    end

    // Toggling every 10 cycles keeps active asserted.
    for (int n = 0; n < 5; n++) begin
      I = ~I;
      push(I, cyc + 5);
      for (int k = 1; k <= 10; k++) begin
        step();
        if (n > 0 || k >= 6) chk("act_keep", active, 1);
      end
    end

    // Edge pulse in the very cycle the countdown reaches zero.
    c = cyc;
    I = 1'b1;
    push(1'b1, c + 5);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 24) begin
        I = 1'b0;
        push(1'b0, cyc + 5);
      end
      if (k >= 6) chk("act_reload", active, 1);
    end

    // Bring o_filt and active high, then reset asynchronously mid-cycle.
    I = 1'b1;
    push(1'b1, cyc + 5);
    repeat (7) step();
    chk("pre_rst_filt", o_filt, 1);
    chk("pre_rst_act", active, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_O", O, 1);
    chk("mid_rst_sync", o_sync, 0);
    chk("mid_rst_filt", o_filt, 0);
    chk("mid_rst_act", active, 0);
    chk("mid_rst_rise", rise, 0);
    step();
    step();
    rst = 1'b0;
    c = cyc;
    push(1'b1, c + 5);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("post_rst_rise", rise, k == 5);
      chk("post_rst_filt", o_filt, k >= 5);
    end

    // Glitch of FILTER_LEN-1 cycles is rejected.
    I = 1'b0;
    push(1'b0, cyc + 5);
    repeat (8) step();
    I = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 2) I = 1'b0;
      chk("glitch_sync", o_sync, (k == 2) || (k == 3));
      chk("glitch_filt", o_filt, 0);
    end
    chk("glitch_fc", dut.fc, 0);

    // A pulse of exactly FILTER_LEN cycles gets through.
    c = cyc;
    I = 1'b1;
    push(1'b1, c + 5);
    push(1'b0, c + 8);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 3) I = 1'b0;
      chk("pulse3_filt", o_filt, (k >= 5) && (k <= 7));
    end

    // Short configuration: SYNC_STAGES=3, FILTER_LEN=1, ACT_TIMEOUT=2.
    I2 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("p_step_sync", o_sync2, k >= 3);
      chk("p_step_filt", o_filt2, k >= 4);
      chk("p_step_rise", rise2, k == 4);
      chk("p_step_act", active2, (k == 5) || (k == 6));
    end
    I2 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) I2 = 1'b1;
      chk("p_pulse_sync", o_sync2, k != 3);
      chk("p_pulse_filt", o_filt2, k != 4);
      chk("p_pulse_fall", fall2, k == 4);
      chk("p_pulse_rise", rise2, k == 5);
    end

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
